// File: rtl/tsc_mem_pkg.sv
// Shared types and constants for the TSC memory port arbiter.
package tsc_mem_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mem_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  // Value placed on a bus bit that this port is not driving.
  localparam logic HIGH_Z_BIT = 1'bz;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter that flags a memory transaction which has stalled too long.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // Count cycles spent waiting; clear on entry, hold once the limit is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST_COUNT)) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single TSC memory port between instruction fetch and load/store.
module mem_port_arbiter
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [WORD_SIZE-1:0] mem_op_count
);

  localparam logic [WORD_SIZE-1:0] BUS_RELEASE = {WORD_SIZE{HIGH_Z_BIT}};

  mem_state_t           state_q, next_state;
  owner_t               owner_q, last_owner_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic [WORD_SIZE-1:0] if_rdata_q, d_rdata_q, op_count_q;
  logic                 if_valid_q, d_valid_q, timeout_err_q;
  logic                 done, abort, wd_expire;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (if_gnt || d_gnt),
    .enable(busy),
    .expire(wd_expire)
  );

  // Grant selection in IDLE: a lone request wins, a tie goes to whoever did not own the port last.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state_q == IDLE) begin
      if (if_req && d_req) begin
        if (last_owner_q == DATA) if_gnt = 1'b1;
        else                      d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  // Next state: start on grant, finish on handshake, abort when the watchdog expires.
  always_comb begin
    next_state = state_q;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_gnt)     next_state = RD;
        else if (d_gnt) next_state = d_we ? WR : RD;
      end
      RD: begin
        if (inputReady) begin
          next_state = IDLE;
          done       = 1'b1;
        end else if (wd_expire) begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      WR: begin
        if (ackOutput) begin
          next_state = IDLE;
          done       = 1'b1;
        end else if (wd_expire) begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, request latches, result registers, valid pulses and bookkeeping counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= FETCH;
      last_owner_q  <= FETCH;
      addr_q        <= '0;
      wdata_q       <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_valid_q    <= 1'b0;
      d_valid_q     <= 1'b0;
      op_count_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= next_state;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if (if_gnt || d_gnt) begin
        owner_q      <= if_gnt ? FETCH : DATA;
        last_owner_q <= if_gnt ? FETCH : DATA;
        addr_q       <= if_gnt ? if_addr : d_addr;
        wdata_q      <= d_wdata;
      end
      if (done || abort) begin
        if (owner_q == FETCH) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= done ? data : '0;
        end else begin
          d_valid_q <= 1'b1;
          if (abort)                       d_rdata_q <= '0;
          else if (state_q == RD)          d_rdata_q <= data;
        end
      end
      if (done)  op_count_q    <= op_count_q + 1'b1;
      if (abort) timeout_err_q <= 1'b1;
    end
  end

  assign readM        = (state_q == RD);
  assign writeM       = (state_q == WR);
  assign busy         = (state_q != IDLE);
  assign address      = addr_q;
  assign data         = (state_q == WR) ? wdata_q : BUS_RELEASE;
  assign if_valid     = if_valid_q;
  assign d_valid      = d_valid_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign timeout_err  = timeout_err_q;
  assign mem_op_count = op_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a simple latency-programmable memory model.
module tb_mem_port_arbiter;

  typedef struct {
    logic [15:0] rdata;
    bit          aborted;
    bit          store;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid;
  logic [15:0] if_rdata, d_rdata, address, mem_op_count;
  logic        readM, writeM, busy, timeout_err;
  logic        inputReady, ackOutput;
  wire  [15:0] data;

  logic        if_req2, inputReady2;
  logic        if_gnt2, if_valid2, d_gnt2, d_valid2, readM2, writeM2, busy2, timeout_err2;
  logic [3:0]  if_rdata2, d_rdata2, address2, op_count2;
  wire  [3:0]  data2;

  logic [15:0] mem [0:255];
  exp_t        if_q[$];
  exp_t        d_q[$];

  int          pass_count = 0;
  int          check_count = 0;
  int          cyc = 0;
  int          rd_delay = 1, wr_delay = 1, rd_cnt = 0, wr_cnt = 0;
  int          rd_high = 0, wr_high = 0;
  int          if_valid_cyc = 0, d_valid_cyc = 0, d_valid_count = 0;
  int          g1, g_if, g_d1, g_d2, g3, g4, g5, snap;
  logic [15:0] exp_count = 0;
  logic [15:0] exp_d_rdata = 0;
  logic [15:0] exp_waddr = 0, exp_wdata = 0;
  logic        exp_err = 0;

  pullup (data);
  pullup (data2);
  assign data = readM ? mem[address[7:0]] : 16'hzzzz;

  mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput),
    .busy(busy), .timeout_err(timeout_err), .mem_op_count(mem_op_count)
  );

  mem_port_arbiter #(.WORD_SIZE(4), .TIMEOUT_CYCLES(2)) dut_narrow (
    .clk(clock), .reset(reset),
    .if_req(if_req2), .if_addr(4'h3), .if_gnt(if_gnt2), .if_valid(if_valid2), .if_rdata(if_rdata2),
    .d_req(1'b0), .d_we(1'b0), .d_addr(4'h0), .d_wdata(4'h0),
    .d_gnt(d_gnt2), .d_valid(d_valid2), .d_rdata(d_rdata2),
    .readM(readM2), .writeM(writeM2), .address(address2), .data(data2),
    .inputReady(inputReady2), .ackOutput(1'b0),
    .busy(busy2), .timeout_err(timeout_err2), .mem_op_count(op_count2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
    else
      pass_count++;
  endtask

  // Memory model: asserts the handshake after a programmable number of strobe cycles (0 = never).
  always @(negedge clock) begin
    if (readM) begin
      rd_cnt++;
      rd_high++;
      inputReady = (rd_delay != 0) && (rd_cnt == rd_delay);
    end else begin
      rd_cnt     = 0;
      inputReady = 1'b0;
    end
    if (writeM) begin
      wr_cnt++;
      wr_high++;
      checkOutput("wr_address", address, exp_waddr);
      checkOutput("wr_data", data, exp_wdata);
      ackOutput = (wr_delay != 0) && (wr_cnt == wr_delay);
    end else begin
      wr_cnt    = 0;
      ackOutput = 1'b0;
    end
  end

  // Scoreboard: every valid pulse pops the oldest expectation of its requester.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (if_valid) begin
        if_valid_cyc = cyc;
        if (if_q.size() == 0) checkOutput("if_valid_unexpected", if_valid, 0);
        else begin
          e = if_q.pop_front();
          if (e.aborted) exp_err = 1'b1; else exp_count++;
          checkOutput("if_rdata", if_rdata, e.rdata);
          checkOutput("if_mem_op_count", mem_op_count, exp_count);
          checkOutput("if_timeout_err", timeout_err, exp_err);
        end
      end
      if (d_valid) begin
        d_valid_cyc = cyc;
        if (d_q.size() == 0) checkOutput("d_valid_unexpected", d_valid, 0);
        else begin
          e = d_q.pop_front();
          if (e.aborted) begin
            exp_err     = 1'b1;
            exp_d_rdata = '0;
          end else begin
            exp_count++;
            if (!e.store) exp_d_rdata = e.rdata;
          end
          checkOutput("d_rdata", d_rdata, exp_d_rdata);
          checkOutput("d_mem_op_count", mem_op_count, exp_count);
          checkOutput("d_timeout_err", timeout_err, exp_err);
        end
      end
    end
    if (d_valid) d_valid_count++;
  end

  // Raise one request, wait (bounded) for its grant, record the expected result, then withdraw.
  task automatic applyStimulus(input bit is_data, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit aborted, output int gnt_cyc);
    exp_t e;
    bit   got = 1'b0;
    @(negedge clock);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 0; n < 40; n++) begin
      #1;
      if (is_data ? d_gnt : if_gnt) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    gnt_cyc = cyc;
    checkOutput(is_data ? "d_gnt_seen" : "if_gnt_seen", got, 1);
    if (got) begin
      e.aborted = aborted;
      e.store   = is_data && we;
      e.rdata   = aborted ? 16'h0000 : mem[addr[7:0]];
      if (is_data && we) begin
        exp_waddr = addr;
        exp_wdata = wdata;
      end
      if (is_data) d_q.push_back(e); else if_q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (is_data) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((if_q.size() != 0 || d_q.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    #2;
    checkOutput("drain", if_q.size() + d_q.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_count = '0; exp_err = 1'b0; exp_d_rdata = '0;
    if_q.delete();
    d_q.delete();
  endtask

  initial begin
    int wraps;
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req2 = 0; inputReady2 = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A5A;
    mem[8'h10] = 16'h6C01;
    #1;
    checkOutput("reset_flags", {readM, writeM, busy, if_valid, d_valid, timeout_err, if_gnt, d_gnt}, 0);
    checkOutput("reset_rdata", {if_rdata, d_rdata}, 0);
    checkOutput("reset_count", mem_op_count, 0);
    checkOutput("reset_bus_hiz", data, 16'hFFFF);
    doReset();

    // Single fetch with one-cycle memory latency.
    rd_delay = 1;
    applyStimulus(0, 0, 16'h0010, 16'h0000, 0, g1);
    checkOutput("t1_readM", readM, 1);
    checkOutput("t1_address", address, 16'h0010);
    waitDrain();
    checkOutput("t1_latency", if_valid_cyc - g1, 2);
    checkOutput("t1_if_rdata", if_rdata, 16'h6C01);
    checkOutput("t1_count", mem_op_count, 1);

    // Simultaneous requests from reset, then a second tie on the valid cycle.
    doReset();
    fork
      applyStimulus(0, 0, 16'h0020, 16'h0000, 0, g_if);
      begin
        applyStimulus(1, 0, 16'h0040, 16'h0000, 0, g_d1);
        applyStimulus(1, 0, 16'h0042, 16'h0000, 0, g_d2);
      end
    join
    waitDrain();
    checkOutput("t2_fetch_after_data", g_if - g_d1, 2);
    checkOutput("t2_second_tie_fetch", g_d2 - g_if, 2);

    // Store acknowledged on the third write cycle.
    wr_delay = 3; wr_high = 0;
    applyStimulus(1, 1, 16'h0080, 16'hBEEF, 0, g3);
    waitDrain();
    checkOutput("t3_write_cycles", wr_high, 3);
    checkOutput("t3_latency", d_valid_cyc - g3, 4);
    checkOutput("t3_bus_release", data, 16'hFFFF);
    checkOutput("t3_writeM_low", writeM, 0);

    // Handshake on the same edge as the watchdog limit completes normally.
    rd_delay = 4;
    applyStimulus(0, 0, 16'h0050, 16'h0000, 0, g4);
    waitDrain();
    checkOutput("t4_edge_no_err", timeout_err, 0);

    // No handshake at all: abort after four RD cycles.
    rd_delay = 0; rd_high = 0;
    applyStimulus(0, 0, 16'h0030, 16'h0000, 1, g4);
    waitDrain();
    checkOutput("t4_rd_cycles", rd_high, 4);
    checkOutput("t4_abort_latency", if_valid_cyc - g4, 5);
    checkOutput("t4_if_rdata_zero", if_rdata, 0);
    checkOutput("t4_count_held", mem_op_count, exp_count);
    repeat (5) @(negedge clock);
    checkOutput("t4_err_sticky", timeout_err, 1);
    rd_delay = 2;
    applyStimulus(0, 0, 16'h0031, 16'h0000, 0, g4);
    waitDrain();

    // Reset in the middle of a store that is never acknowledged.
    wr_delay = 0;
    applyStimulus(1, 1, 16'h0090, 16'h1234, 0, g5);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_writeM_drop", writeM, 0);
    checkOutput("t5_busy_drop", busy, 0);
    checkOutput("t5_valids_drop", {if_valid, d_valid}, 0);
    checkOutput("t5_bus_hiz", data, 16'hFFFF);
    d_q.delete();
    exp_count = '0; exp_err = 1'b0; exp_d_rdata = '0;
    snap = d_valid_count;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("t5_no_d_valid", d_valid_count - snap, 0);
    checkOutput("t5_err_cleared", timeout_err, 0);
    checkOutput("t5_count_cleared", mem_op_count, 0);

    // Counter wrap on the 4-bit instance: the sixteenth completion reads back zero.
    wraps = 0;
    if_req2 = 1'b1; inputReady2 = 1'b1;
    for (int n = 0; n < 100 && wraps < 16; n++) begin
      @(negedge clock);
      #1;
      if (if_valid2) begin
        wraps++;
        if (wraps == 15) checkOutput("t6_count_max", op_count2, 4'hF);
        if (wraps == 16) checkOutput("t6_count_wrap", op_count2, 4'h0);
      end
    end
    if_req2 = 1'b0;
    checkOutput("t6_completions", wraps, 16);
    checkOutput("t6_no_err", timeout_err2, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared TSC memory port (readM/writeM, address, bidirectional data, inputReady/ackOutput) for the multi-cycle CPU.
- Arbitrates between the instruction-fetch requester and the load/store data requester.
- Runs one memory transaction at a time: latches the request, drives the bus, waits for the memory handshake, then returns read data or write completion to the owning requester.
- Includes a watchdog that aborts hung transactions.

Parameters:
- WORD_SIZE, 16, width of address and data words.
- TIMEOUT_CYCLES, 64, maximum cycles spent in RD/WR before abort; legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_gnt.
- if_addr  in  WORD_SIZE  fetch address; sampled on the if_gnt cycle.
- if_gnt  out  1  combinational accept pulse.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  WORD_SIZE  fetched instruction (registered).
- d_req  in  1  data request; held high until d_gnt.
- d_we  in  1  1 = store, 0 = load; sampled on the d_gnt cycle.
- d_addr  in  WORD_SIZE  data address; sampled on the d_gnt cycle.
- d_wdata  in  WORD_SIZE  store data; sampled on the d_gnt cycle.
- d_gnt  out  1  combinational accept pulse.
- d_valid  out  1  one-cycle pulse; load data is ready, or store is complete.
- d_rdata  out  WORD_SIZE  load data (registered).
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  memory data bus; driven only in WR, otherwise high-Z.
- inputReady  in  1  memory read data valid.
- ackOutput  in  1  memory write accepted.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky abort flag.
- mem_op_count  out  WORD_SIZE  completed transactions; wraps modulo 2^WORD_SIZE.

Behaviour:
- Reset: state = IDLE, last_owner = FETCH, counters = 0, timeout_err = 0. All strobes, valids, grants and busy are 0; rdata outputs are 0; data is high-Z. A reset mid-transaction drops the transaction immediately and no valid pulse follows.
- States: IDLE, RD, WR.
- IDLE, grant selection:
  - Only one request present: grant it.
  - Both present: grant the requester that is not last_owner, so round-robin on ties; the first tie after reset goes to data.
  - Grant (if_gnt or d_gnt) is asserted combinationally in the same IDLE cycle.
  - On the grant edge: latch owner, address, we and wdata; set last_owner = owner; go to RD (fetch, or data with d_we = 0) or WR (d_we = 1).
- RD:
  - readM = 1 and address = latched address from the cycle after the grant.
  - On the edge where inputReady = 1: capture data into the owner's rdata, assert the owner's valid for the next cycle, increment mem_op_count, return to IDLE.
  - Minimum latency: grant at cycle t, inputReady at t+1, valid at t+2.
  - ackOutput is ignored in RD.
- WR:
  - writeM = 1, address and data driven.
  - On the edge where ackOutput = 1: d_valid pulses next cycle, increment mem_op_count, return to IDLE.
  - inputReady is ignored in WR.
- Valid cycle: state is already IDLE, so a new grant may be issued in the same cycle as valid (back-to-back transactions).
- Watchdog:
  - Cycle counter clears on entry to RD/WR.
  - If the handshake has not arrived when the counter reaches TIMEOUT_CYCLES-1: abort to IDLE, set timeout_err (sticky until reset), pulse the owner's valid with rdata = 0, leave mem_op_count unchanged.
  - A handshake arriving on the same edge as the timeout wins: normal completion, no error.
- readM and writeM are never both high. address holds its latched value outside RD/WR.
- Requests arriving while busy wait; their grant is withheld until IDLE.
- Deasserting req before grant is legal: the request is simply withdrawn.

Decomposition:
- Package tsc_mem_pkg holds:
  - WORD_SIZE default.
  - State encoding: IDLE, RD, WR.
  - Owner encoding: FETCH = 0, DATA = 1.
  - High-Z data constant.
- One sub-module, mem_watchdog: counter with clear, enable and expire output, parameterised by TIMEOUT_CYCLES.
- The FSM, round-robin tie-break and bus drive stay in the top module.

Test Plan:
1. Fetch only: if_addr = 16'h0010, memory returns 16'h6C01 one cycle after readM. Required: if_gnt at t, readM/address = 16'h0010 at t+1, if_valid with if_rdata = 16'h6C01 at t+2, mem_op_count = 1.
2. Simultaneous if_req and d_req (load at 16'h0040) from reset. Required: data is granted first; fetch is granted on d_valid's cycle; the next tie goes to fetch.
3. Store: d_we = 1, d_addr = 16'h0080, d_wdata = 16'hBEEF, ackOutput after 3 cycles. Required: writeM high for 3 cycles with data = 16'hBEEF, d_valid one cycle after ack, bus high-Z afterwards.
4. Timeout: TIMEOUT_CYCLES = 4, inputReady never rises. Required: abort after 4 cycles in RD, if_valid with if_rdata = 0, timeout_err = 1 persisting, mem_op_count unchanged.
5. Reset asserted mid-WR. Required: writeM, busy and valids drop asynchronously, data goes high-Z, no d_valid after release.
6. Wrap: preload mem_op_count = 16'hFFFF via repeated ops. Required: the next completion yields 0.
